// File: rtl/cpu_types_pkg.sv
// Shared CPU types: hazard-sequencer states and register index type.
package cpu_types_pkg;

  localparam int unsigned REGIDX_W = 5;

  typedef logic [REGIDX_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_DWAIT,
    HZ_DRAIN,
    HZ_HALTED
  } hzstate_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: PC/latch write enables and flushes from cache
// handshakes, load-use, MEM-stage redirects and halt, plus perf counters.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             exmem_halt,
  input  logic             memwb_halt,
  input  logic             idex_MemRead,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             mem_pc_redirect,
  output logic             pc_WEN,
  output logic             ifid_WEN,
  output logic             idex_WEN,
  output logic             exmem_WEN,
  output logic             memwb_WEN,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hzstate_t state, state_nxt;
  logic     dmem_busy;
  logic     load_use;
  logic     redirect_taken;

  assign dmem_busy = (exmem_MemRead | exmem_MemWrite) & ~dhit;
  assign load_use  = idex_MemRead & (idex_rt != '0) &
                     ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= HZ_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    redirect_taken = 1'b0;
    {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN}  = 5'b00000;
    {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b0000;
    case (state)
      HZ_RUN, HZ_DWAIT: begin
        // A redirect during a data wait is held off until the dhit cycle.
        if (dmem_busy) begin
          memwb_flush = 1'b1;
        end else if (mem_pc_redirect) begin
          pc_WEN         = 1'b1;
          ifid_flush     = 1'b1;
          idex_flush     = 1'b1;
          exmem_flush    = 1'b1;
          memwb_WEN      = 1'b1;
          redirect_taken = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
          exmem_WEN  = 1'b1;
          memwb_WEN  = 1'b1;
        end else if (!ihit) begin
          ifid_flush = 1'b1;
          idex_WEN   = 1'b1;
          exmem_WEN  = 1'b1;
          memwb_WEN  = 1'b1;
        end else begin
          {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN} = 5'b11111;
        end

        if (state == HZ_DWAIT) begin
          if (!dmem_busy) state_nxt = HZ_RUN;
        end else if (dmem_busy) begin
          state_nxt = HZ_DWAIT;
        end else if (exmem_halt) begin
          state_nxt = HZ_DRAIN;
        end
      end
      HZ_DRAIN: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        memwb_WEN   = 1'b1;
        if (memwb_halt) state_nxt = HZ_HALTED;
      end
      default: begin
      end
    endcase

    if (!nRST) begin
      redirect_taken = 1'b0;
      {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN}  = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b0000;
    end
  end

  assign halt = (state == HZ_HALTED);

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (state != HZ_HALTED),
    .count (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   ((state != HZ_HALTED) & ~pc_WEN),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (redirect_taken),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b1, dhit = 1'b0;
  logic exmem_MemRead = 1'b0, exmem_MemWrite = 1'b0;
  logic exmem_halt = 1'b0, memwb_halt = 1'b0;
  logic idex_MemRead = 1'b0, mem_pc_redirect = 1'b0;
  logic [4:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
  logic pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
    .exmem_halt(exmem_halt), .memwb_halt(memwb_halt),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .mem_pc_redirect(mem_pc_redirect),
    .pc_WEN(pc_WEN), .ifid_WEN(ifid_WEN), .idex_WEN(idex_WEN),
    .exmem_WEN(exmem_WEN), .memwb_WEN(memwb_WEN),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt(halt),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // {pc, ifid, idex, exmem, memwb WEN, ifid, idex, exmem, memwb flush}
  localparam logic [8:0] V_NONE   = 9'b00000_0000;
  localparam logic [8:0] V_NORMAL = 9'b11111_0000;
  localparam logic [8:0] V_DBUSY  = 9'b00000_0001;
  localparam logic [8:0] V_REDIR  = 9'b10001_1110;
  localparam logic [8:0] V_LDUSE  = 9'b00011_0100;
  localparam logic [8:0] V_IMISS  = 9'b00111_1000;
  localparam logic [8:0] V_DRAIN  = 9'b00001_1110;

  wire [8:0] got_vec = {pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
                        ifid_flush, idex_flush, exmem_flush, memwb_flush};

  // Behavioural model: a few flags for "waiting on dcache", "draining", "halted".
  bit m_wait = 0, m_drain = 0, m_halted = 0;
  int m_cyc = 0, m_stall = 0, m_flush = 0;

  function automatic bit model_busy();
    return (exmem_MemRead || exmem_MemWrite) && !dhit;
  endfunction

  function automatic logic [8:0] model_out();
    if (!nRST || m_halted) return V_NONE;
    if (m_drain) return V_DRAIN;
    if (model_busy()) return V_DBUSY;
    if (mem_pc_redirect) return V_REDIR;
    if (idex_MemRead && idex_rt != 0 &&
        (idex_rt == ifid_rs || idex_rt == ifid_rt)) return V_LDUSE;
    if (!ihit) return V_IMISS;
    return V_NORMAL;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_wait = 0; m_drain = 0; m_halted = 0;
      m_cyc = 0; m_stall = 0; m_flush = 0;
    end else begin
      logic [8:0] e;
      bit busy;
      e = model_out();
      busy = model_busy();
      if (!m_halted) begin
        if (m_cyc < MAXC) m_cyc++;
        if (!e[8] && m_stall < MAXC) m_stall++;
        if (!m_drain && !busy && mem_pc_redirect && m_flush < MAXC) m_flush++;
      end
      if (m_drain) begin
        if (memwb_halt) begin m_halted = 1; m_drain = 0; end
      end else if (!m_halted) begin
        if (m_wait) m_wait = busy;
        else if (busy) m_wait = 1;
        else if (exmem_halt) m_drain = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    chk("model_outs", 64'(got_vec), 64'(model_out()));
    chk("model_halt", 64'(halt), 64'(m_halted));
    chk("model_cycle", 64'(cycle_cnt), 64'(m_cyc));
    chk("model_stall", 64'(stall_cnt), 64'(m_stall));
    chk("model_flush", 64'(flush_cnt), 64'(m_flush));
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; exmem_MemRead = 0; exmem_MemWrite = 0;
    exmem_halt = 0; memwb_halt = 0; idex_MemRead = 0; mem_pc_redirect = 0;
    idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
  endtask

  initial begin
    idle();
    step(); step();
    #1;
    chk("reset_outs", 64'(got_vec), 64'(V_NONE));
    chk("reset_cycle", 64'(cycle_cnt), 64'd0);
    chk("reset_halt", 64'(halt), 64'd0);
    nRST = 1;
    repeat (10) step();
    chk("run10_cycle", 64'(cycle_cnt), 64'd10);
    chk("run10_stall", 64'(stall_cnt), 64'd0);
    chk("run10_outs", 64'(got_vec), 64'(V_NORMAL));

    // load-use stall, then the same with rt=0
    idex_MemRead = 1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 chk("lduse_outs", 64'(got_vec), 64'(V_LDUSE));
    step();
    idex_rt = 5'd0; ifid_rs = 5'd0;
    #1 chk("lduse_rt0_outs", 64'(got_vec), 64'(V_NORMAL));
    chk("lduse_stall", 64'(stall_cnt), 64'd1);
    step();
    idle();

    // three-cycle data-cache wait
    exmem_MemRead = 1; dhit = 0;
    repeat (3) begin
      #1 chk("dwait_outs", 64'(got_vec), 64'(V_DBUSY));
      step();
    end
    dhit = 1;
    #1 chk("dhit_outs", 64'(got_vec), 64'(V_NORMAL));
    chk("dwait_stall", 64'(stall_cnt), 64'd4);
    step();
    idle();

    // redirect beats load-use
    mem_pc_redirect = 1; idex_MemRead = 1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 chk("redir_lduse_outs", 64'(got_vec), 64'(V_REDIR));
    step();
    idle();
    #1 chk("redir_flushcnt", 64'(flush_cnt), 64'd1);
    chk("redir_stall", 64'(stall_cnt), 64'd4);

    // redirect deferred by a busy store
    exmem_MemWrite = 1; dhit = 0; mem_pc_redirect = 1;
    #1 chk("redir_busy_outs", 64'(got_vec), 64'(V_DBUSY));
    step();
    chk("redir_busy_flushcnt", 64'(flush_cnt), 64'd1);
    dhit = 1;
    #1 chk("redir_dhit_outs", 64'(got_vec), 64'(V_REDIR));
    step();
    idle();
    #1 chk("redir_dhit_flushcnt", 64'(flush_cnt), 64'd2);
    chk("redir_dhit_stall", 64'(stall_cnt), 64'd5);

    // halt: one DRAIN cycle (redirect ignored), then HALTED
    exmem_halt = 1;
    #1 chk("halt_run_outs", 64'(got_vec), 64'(V_NORMAL));
    step();
    exmem_halt = 0; memwb_halt = 1; mem_pc_redirect = 1;
    #1 chk("drain_outs", 64'(got_vec), 64'(V_DRAIN));
    step();
    idle();
    #1 chk("halted_flag", 64'(halt), 64'd1);
    chk("halted_outs", 64'(got_vec), 64'(V_NONE));
    chk("halted_cycle", 64'(cycle_cnt), 64'd21);
    chk("halted_stall", 64'(stall_cnt), 64'd6);
    chk("halted_flushcnt", 64'(flush_cnt), 64'd2);
    repeat (3) step();
    chk("halted_frozen", 64'(cycle_cnt), 64'd21);

    // asynchronous reset in the middle of DRAIN
    nRST = 0; #1 nRST = 1;
    step();
    exmem_halt = 1;
    step();
    exmem_halt = 0;
    #1 chk("drain2_outs", 64'(got_vec), 64'(V_DRAIN));
    nRST = 0;
    #1;
    chk("rst_drain_outs", 64'(got_vec), 64'(V_NONE));
    chk("rst_drain_halt", 64'(halt), 64'd0);
    chk("rst_drain_cycle", 64'(cycle_cnt), 64'd0);
    chk("rst_drain_stall", 64'(stall_cnt), 64'd0);
    step();
    nRST = 1;

    // counter saturation
    repeat (300) step();
    chk("sat_cycle", 64'(cycle_cnt), 64'(MAXC));
    chk("sat_stall", 64'(stall_cnt), 64'd0);

    // randomized traffic, checked every cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      ihit            = ($urandom_range(0, 3) != 0);
      dhit            = ($urandom_range(0, 1) != 0);
      exmem_MemRead   = ($urandom_range(0, 3) == 0);
      exmem_MemWrite  = ($urandom_range(0, 5) == 0);
      exmem_halt      = ($urandom_range(0, 40) == 0);
      memwb_halt      = ($urandom_range(0, 3) == 0);
      idex_MemRead    = ($urandom_range(0, 1) != 0);
      idex_rt         = 5'($urandom_range(0, 3));
      ifid_rs         = 5'($urandom_range(0, 3));
      ifid_rt         = 5'($urandom_range(0, 3));
      mem_pc_redirect = ($urandom_range(0, 5) == 0);
      if (!nRST) nRST = 1;
      else if ($urandom_range(0, 120) == 0) nRST = 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline. Generates write-enable and flush for the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) from:
- cache handshakes (ihit, dhit);
- load-use hazards;
- taken branches/jumps resolved in MEM;
- halt.
Small FSM handles data-cache waits and halt drain. Saturating performance counters for cycles, stalls and flushes.

Parameters:
CNT_W, 32, width of each performance counter
REG_W, 5, register index width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction cache hit this cycle
dhit  in  1  data cache hit this cycle
exmem_MemRead  in  1  load in EX/MEM latch
exmem_MemWrite  in  1  store in EX/MEM latch
exmem_halt  in  1  halt in EX/MEM latch
memwb_halt  in  1  halt in MEM/WB latch
idex_MemRead  in  1  load in ID/EX latch
idex_rt  in  REG_W  load destination in ID/EX
ifid_rs  in  REG_W  source rs of instruction in IF/ID
ifid_rt  in  REG_W  source rt of instruction in IF/ID
mem_pc_redirect  in  1  taken branch or jump resolved in MEM
pc_WEN  out  1  PC update enable
ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN  out  1 each  latch write enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch bubble insert (flush has priority over WEN inside the latch)
halt  out  1  sticky CPU halted
cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- States:
  - RUN: normal.
  - DWAIT: data access outstanding.
  - DRAIN: halt travelling to WB.
  - HALTED: terminal.
- Reset: state=RUN, counters=0, halt=0.
  - While nRST low, all WEN=0 and all flush=0.
- Outputs are combinational from state and inputs. FSM and counters update on posedge.
- dmem_busy = (exmem_MemRead|exmem_MemWrite) & !dhit.
- RUN/DWAIT output priority, highest first:
  1. dmem_busy:
     - pc/ifid/idex/exmem WEN=0; memwb_flush=1.
     - No other flush asserted, including redirect; redirect is taken after dhit.
  2. mem_pc_redirect:
     - pc_WEN=1; ifid_flush=idex_flush=exmem_flush=1; memwb_WEN=1.
     - Load-use and ihit are ignored this cycle.
  3. load-use = idex_MemRead & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt):
     - pc_WEN=ifid_WEN=0; idex_flush=1; exmem_WEN=memwb_WEN=1.
  4. !ihit:
     - pc_WEN=0; ifid_flush=1; idex/exmem/memwb WEN=1.
  5. Otherwise all WEN=1, all flush=0.
- Transitions:
  - RUN -> DRAIN if exmem_halt & !dmem_busy.
  - RUN -> DWAIT if dmem_busy.
  - DWAIT -> RUN on the dhit cycle. The dhit cycle itself uses the RUN priority rules.
  - DRAIN -> HALTED when memwb_halt=1.
  - HALTED holds until reset.
- DRAIN outputs:
  - pc_WEN=0; ifid_flush=idex_flush=exmem_flush=1; memwb_WEN=1.
  - A redirect present in DRAIN is ignored.
- HALTED outputs: all WEN=0, all flush=0, halt=1.
- Counters:
  - cycle_cnt increments every cycle not HALTED.
  - stall_cnt increments on any cycle with pc_WEN=0, outside HALTED.
  - flush_cnt increments once per redirect cycle.
  - All three saturate at all-ones (no wrap).
- Reset mid-DWAIT or mid-DRAIN returns to RUN immediately (asynchronous); the bench must see WEN=0 during reset.

Decomposition:
- Shared package (cpu_types_pkg):
  - typedef enum logic [1:0] hzstate_t {HZ_RUN, HZ_DWAIT, HZ_DRAIN, HZ_HALTED};
  - regbits_t for REG_W indices.
- Sub-module sat_counter (CNT_W, inc -> count), instantiated three times.
- FSM and priority logic stay in the top.

Test Plan:
- Reset then ihit=1 with no hazards: all WEN=1, flush=0. After 10 cycles cycle_cnt=10, stall_cnt=0.
- idex_MemRead=1, idex_rt=5, ifid_rs=5: exactly one cycle of pc_WEN=0, ifid_WEN=0, idex_flush=1.
  - Same stimulus with idex_rt=0: no stall.
- exmem_MemRead=1, dhit=0 for 3 cycles then 1: state DWAIT for 3 cycles with memwb_flush=1.
  - Advance resumes on the dhit cycle; stall_cnt=3.
- mem_pc_redirect=1 together with a load-use match: pc_WEN=1, ifid/idex/exmem flush=1, flush_cnt +1.
- mem_pc_redirect=1 while dmem_busy: no flush that cycle; redirect is honoured on the dhit cycle.
- exmem_halt=1, then memwb_halt=1 next cycle: DRAIN for 1 cycle, then HALTED with halt=1 and all WEN=0.
  - cycle_cnt frozen.
  - Assert nRST=0 mid-DRAIN: halt=0 and counters=0 immediately.
